// File: rtl/reloj_contador.sv
// ============================================================================
// reloj_contador : 24 h time-of-day counter with alarm set/match and ring FSM
// Revision 1.0
// ============================================================================
`default_nettype none

module reloj_contador #(
  parameter int TICKS_PER_SEC = 50000000,
  parameter int RING_SECS     = 60
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic [1:0] SET_MODE,
  input  logic       INC_H,
  input  logic       INC_M,
  input  logic       ALARM_EN,
  input  logic       ALARM_ACK,
  output logic [5:0] HORA,
  output logic [5:0] MINUTO,
  output logic [5:0] SEGUNDO,
  output logic [5:0] AHORA,
  output logic [5:0] AMIN,
  output logic       ALARM,
  output logic       RING,
  output logic       TICK
);

  localparam int c_PRE_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam int c_RNG_W = (RING_SECS > 1) ? $clog2(RING_SECS) : 1;
  localparam logic [c_PRE_W-1:0] c_PRE_MAX = c_PRE_W'(TICKS_PER_SEC - 1);
  localparam logic [c_RNG_W-1:0] c_RNG_MAX = c_RNG_W'(RING_SECS - 1);

  typedef enum logic [0:0] {
    S_IDLE    = 1'b0,
    S_RINGING = 1'b1
  } ring_state_t;

  ring_state_t        state_q, state_d;
  logic [c_PRE_W-1:0] pre_q, pre_d;
  logic [c_RNG_W-1:0] rcnt_q, rcnt_d;
  logic [5:0]         hora_q, hora_d, min_q, min_d, seg_q, seg_d;
  logic [5:0]         ahora_q, ahora_d, amin_q, amin_d;
  logic               alarm_q, alarm_d, tick_q, tick_d;
  logic               prev_h_q, prev_h_d, prev_m_q, prev_m_d;

  logic w_set_time, w_set_alarm, w_edge_h, w_edge_m, w_release, w_match;

  // Defensive >= compare keeps any corrupted value from sticking out of range.
  function automatic logic [5:0] wrap_inc(input logic [5:0] v, input logic [5:0] top);
    return (v >= top) ? 6'd0 : v + 6'd1;
  endfunction

  always_comb begin
    state_d  = state_q;
    pre_d    = pre_q;
    rcnt_d   = rcnt_q;
    hora_d   = hora_q;
    min_d    = min_q;
    seg_d    = seg_q;
    ahora_d  = ahora_q;
    amin_d   = amin_q;
    tick_d   = 1'b0;

    w_set_time  = (SET_MODE == 2'd1);
    w_set_alarm = (SET_MODE == 2'd2);
    w_edge_h    = INC_H & ~prev_h_q;
    w_edge_m    = INC_M & ~prev_m_q;
    prev_h_d    = INC_H;
    prev_m_d    = INC_M;
    alarm_d     = w_set_alarm;

    if (w_set_time) begin
      pre_d = '0;
      seg_d = 6'd0;
      if (w_edge_h) hora_d = wrap_inc(hora_q, 6'd23);
      if (w_edge_m) min_d  = wrap_inc(min_q, 6'd59);
    end else if (pre_q >= c_PRE_MAX) begin
      pre_d  = '0;
      tick_d = 1'b1;
    end else begin
      pre_d = pre_q + 1'b1;
    end

    if (tick_d) begin
      seg_d = wrap_inc(seg_q, 6'd59);
      if (seg_q >= 6'd59) begin
        min_d = wrap_inc(min_q, 6'd59);
        if (min_q >= 6'd59) hora_d = wrap_inc(hora_q, 6'd23);
      end
    end

    if (w_set_alarm) begin
      if (w_edge_h) ahora_d = wrap_inc(ahora_q, 6'd23);
      if (w_edge_m) amin_d  = wrap_inc(amin_q, 6'd59);
    end

    // Only a tick-driven minute rollover can start ringing; release wins.
    w_release = ALARM_ACK | ~ALARM_EN | w_set_time;
    w_match   = tick_d & (seg_q >= 6'd59) & (hora_d == ahora_q) & (min_d == amin_q);

    case (state_q)
      S_IDLE: begin
        if (w_match && !w_release) begin
          state_d = S_RINGING;
          rcnt_d  = '0;
        end
      end
      S_RINGING: begin
        if (w_release || (tick_d && (rcnt_q >= c_RNG_MAX))) begin
          state_d = S_IDLE;
        end else if (tick_d) begin
          rcnt_d = rcnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q  <= S_IDLE;
      pre_q    <= '0;
      rcnt_q   <= '0;
      hora_q   <= 6'd0;
      min_q    <= 6'd0;
      seg_q    <= 6'd0;
      ahora_q  <= 6'd7;
      amin_q   <= 6'd0;
      alarm_q  <= 1'b0;
      tick_q   <= 1'b0;
      prev_h_q <= 1'b0;
      prev_m_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pre_q    <= pre_d;
      rcnt_q   <= rcnt_d;
      hora_q   <= hora_d;
      min_q    <= min_d;
      seg_q    <= seg_d;
      ahora_q  <= ahora_d;
      amin_q   <= amin_d;
      alarm_q  <= alarm_d;
      tick_q   <= tick_d;
      prev_h_q <= prev_h_d;
      prev_m_q <= prev_m_d;
    end
  end

  assign HORA    = hora_q;
  assign MINUTO  = min_q;
  assign SEGUNDO = seg_q;
  assign AHORA   = ahora_q;
  assign AMIN    = amin_q;
  assign ALARM   = alarm_q;
  assign RING    = (state_q == S_RINGING);
  assign TICK    = tick_q;

endmodule

`default_nettype wire

// File: tb/tb_reloj_contador.sv
// Bench for reloj_contador: directed table, alarm/rollover sequences, random run vs. model.
`default_nettype none

module tb_reloj_contador;

  localparam int T = 4;
  localparam int R = 60;

  logic       CLK = 1'b0;
  logic       RESET_N = 1'b1;
  logic [1:0] SET_MODE = 2'd0;
  logic       INC_H = 1'b0, INC_M = 1'b0, ALARM_EN = 1'b0, ALARM_ACK = 1'b0;
  logic [5:0] HORA, MINUTO, SEGUNDO, AHORA, AMIN;
  logic       ALARM, RING, TICK;

  int checks = 0;
  int errors = 0;

  // Reference model: time kept as seconds since midnight.
  int m_tod, m_ah, m_am, m_pre, m_ring, m_rcnt, m_ph, m_pm, m_alarm, m_tick;

  reloj_contador #(.TICKS_PER_SEC(T), .RING_SECS(R)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .SET_MODE(SET_MODE), .INC_H(INC_H), .INC_M(INC_M),
    .ALARM_EN(ALARM_EN), .ALARM_ACK(ALARM_ACK), .HORA(HORA), .MINUTO(MINUTO),
    .SEGUNDO(SEGUNDO), .AHORA(AHORA), .AMIN(AMIN), .ALARM(ALARM), .RING(RING), .TICK(TICK)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [1:0] mode;
    logic       h, m;
    int         hora, min, seg, ah, am, al, tk;
  } vec_t;

  vec_t tbl [12];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_tod = 0; m_ah = 7; m_am = 0; m_pre = 0; m_ring = 0; m_rcnt = 0;
    m_ph = 0; m_pm = 0; m_alarm = 0; m_tick = 0;
  endtask

  task automatic model_step();
    bit st, sa, eh, em, tk;
    int h, m;
    st = (SET_MODE == 2'd1);
    sa = (SET_MODE == 2'd2);
    eh = INC_H && (m_ph == 0);
    em = INC_M && (m_pm == 0);
    m_ph = int'(INC_H);
    m_pm = int'(INC_M);
    tk = 0;
    if (st) begin
      m_pre = 0;
      h = m_tod / 3600;
      m = (m_tod / 60) % 60;
      if (eh) h = (h + 1) % 24;
      if (em) m = (m + 1) % 60;
      m_tod = h * 3600 + m * 60;
    end else if (m_pre == T - 1) begin
      m_pre = 0;
      tk = 1;
    end else begin
      m_pre++;
    end
    if (tk) m_tod = (m_tod + 1) % 86400;
    if (m_ring != 0) begin
      if (ALARM_ACK || !ALARM_EN || st || (tk && m_rcnt == R - 1)) m_ring = 0;
      else if (tk) m_rcnt++;
    end else if (tk && (m_tod % 60 == 0) && (m_tod / 60 == m_ah * 60 + m_am)
                 && ALARM_EN && !ALARM_ACK) begin
      m_ring = 1;
      m_rcnt = 0;
    end
    if (sa) begin
      if (eh) m_ah = (m_ah + 1) % 24;
      if (em) m_am = (m_am + 1) % 60;
    end
    m_alarm = sa ? 1 : 0;
    m_tick  = tk ? 1 : 0;
  endtask

  task automatic cmp_model();
    check("hora",    int'(HORA),    m_tod / 3600);
    check("minuto",  int'(MINUTO),  (m_tod / 60) % 60);
    check("segundo", int'(SEGUNDO), m_tod % 60);
    check("ahora",   int'(AHORA),   m_ah);
    check("amin",    int'(AMIN),    m_am);
    check("alarm",   int'(ALARM),   m_alarm);
    check("ring",    int'(RING),    m_ring);
    check("tick",    int'(TICK),    m_tick);
  endtask

  task automatic step(input logic [1:0] mode, input logic h, input logic m,
                      input logic en, input logic ack);
    SET_MODE = mode; INC_H = h; INC_M = m; ALARM_EN = en; ALARM_ACK = ack;
    @(posedge CLK);
    model_step();
    #1;
    cmp_model();
  endtask

  task automatic do_reset();
    RESET_N = 1'b0;
    SET_MODE = 2'd0; INC_H = 1'b0; INC_M = 1'b0; ALARM_EN = 1'b0; ALARM_ACK = 1'b0;
    #2;
    model_reset();
    cmp_model();
    @(posedge CLK);
    @(posedge CLK);
    #1;
    RESET_N = 1'b1;
  endtask

  task automatic wait_ring(input logic target, input int maxc, input logic en, input logic ack);
    bit ok;
    ok = 0;
    for (int i = 0; i < maxc; i++) begin
      step(2'd0, 1'b0, 1'b0, en, ack);
      if (RING == target) begin
        ok = 1;
        break;
      end
    end
    check("wait_ring_timeout", int'(ok), 1);
  endtask

  task automatic pulse(input logic [1:0] mode, input logic h, input logic m, input logic en);
    step(mode, h, m, en, 1'b0);
    step(mode, 1'b0, 1'b0, en, 1'b0);
  endtask

  initial begin
    int n, rc, r;

    tbl[0]  = '{2'd1, 1'b1, 1'b0, 1, 0, 0, 7, 0, 0, 0};
    tbl[1]  = '{2'd1, 1'b1, 1'b0, 1, 0, 0, 7, 0, 0, 0};
    tbl[2]  = '{2'd1, 1'b0, 1'b0, 1, 0, 0, 7, 0, 0, 0};
    tbl[3]  = '{2'd1, 1'b1, 1'b1, 2, 1, 0, 7, 0, 0, 0};
    tbl[4]  = '{2'd0, 1'b0, 1'b0, 2, 1, 0, 7, 0, 0, 0};
    tbl[5]  = '{2'd0, 1'b1, 1'b0, 2, 1, 0, 7, 0, 0, 0};
    tbl[6]  = '{2'd0, 1'b0, 1'b0, 2, 1, 0, 7, 0, 0, 0};
    tbl[7]  = '{2'd0, 1'b0, 1'b0, 2, 1, 1, 7, 0, 0, 1};
    tbl[8]  = '{2'd2, 1'b0, 1'b1, 2, 1, 1, 7, 1, 1, 0};
    tbl[9]  = '{2'd2, 1'b1, 1'b1, 2, 1, 1, 8, 1, 1, 0};
    tbl[10] = '{2'd3, 1'b0, 1'b0, 2, 1, 1, 8, 1, 0, 0};
    tbl[11] = '{2'd0, 1'b0, 1'b0, 2, 1, 2, 8, 1, 0, 1};

    #1;
    do_reset();

    // Directed table: set-time/set-alarm edges and first ticks
    foreach (tbl[i]) begin
      step(tbl[i].mode, tbl[i].h, tbl[i].m, 1'b0, 1'b0);
      check("tbl_hora",  int'(HORA),    tbl[i].hora);
      check("tbl_min",   int'(MINUTO),  tbl[i].min);
      check("tbl_seg",   int'(SEGUNDO), tbl[i].seg);
      check("tbl_ahora", int'(AHORA),   tbl[i].ah);
      check("tbl_amin",  int'(AMIN),    tbl[i].am);
      check("tbl_alarm", int'(ALARM),   tbl[i].al);
      check("tbl_tick",  int'(TICK),    tbl[i].tk);
      check("tbl_ring",  int'(RING),    0);
    end

    // Preload 23:59:59 and roll over the day
    do_reset();
    for (int i = 0; i < 23; i++) pulse(2'd1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 59; i++) pulse(2'd1, 1'b0, 1'b1, 1'b0);
    check("preload_hora", int'(HORA), 23);
    check("preload_min",  int'(MINUTO), 59);
    n = 0;
    for (int i = 0; i < 59 * T; i++) begin
      step(2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      if (TICK) n++;
    end
    check("ticks_59", n, 59);
    check("pre_roll_seg", int'(SEGUNDO), 59);
    n = 0;
    for (int i = 0; i < T; i++) begin
      step(2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      if (TICK) n++;
    end
    check("roll_tick_count", n, 1);
    check("roll_hms", {26'd0, HORA} + int'(MINUTO) + int'(SEGUNDO), 0);

    // Alarm at 00:01, ring duration, ack, suppression, reset mid-ring
    do_reset();
    for (int i = 0; i < 17; i++) pulse(2'd2, 1'b1, 1'b0, 1'b1);
    pulse(2'd2, 1'b0, 1'b1, 1'b1);
    check("alarm_set_h", int'(AHORA), 0);
    check("alarm_set_m", int'(AMIN), 1);
    step(2'd1, 1'b0, 1'b0, 1'b1, 1'b0);
    wait_ring(1'b1, 61 * T, 1'b1, 1'b0);
    check("ring_at_min", int'(MINUTO), 1);
    check("ring_at_sec", int'(SEGUNDO), 0);
    check("ring_at_tick", int'(TICK), 1);
    n = 0;
    for (int i = 0; i < 70 * T; i++) begin
      step(2'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      if (TICK) n++;
      if (!RING) break;
    end
    check("ring_duration_ticks", n, R);

    pulse(2'd2, 1'b0, 1'b1, 1'b1);
    pulse(2'd2, 1'b0, 1'b1, 1'b1);
    wait_ring(1'b1, 70 * T, 1'b1, 1'b0);
    step(2'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    check("ack_silences", int'(RING), 0);

    pulse(2'd2, 1'b0, 1'b1, 1'b1);
    rc = 0;
    for (int i = 0; i < 70 * T; i++) begin
      step(2'd0, 1'b0, 1'b0, 1'b1, 1'b1);
      if (RING) rc++;
    end
    check("ack_suppresses", rc, 0);
    check("suppress_passed_match", int'(MINUTO), 4);

    pulse(2'd2, 1'b0, 1'b1, 1'b1);
    wait_ring(1'b1, 70 * T, 1'b1, 1'b0);
    do_reset();
    check("reset_ring", int'(RING), 0);
    check("reset_ahora", int'(AHORA), 7);

    // Randomized run against the model
    for (int i = 0; i < 2500; i++) begin
      logic [1:0] md;
      r = int'($urandom_range(0, 9));
      md = (r < 6) ? 2'd0 : (r == 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
      step(md, ($urandom % 4) == 0, ($urandom % 4) == 0,
           ($urandom % 8) != 0, ($urandom % 32) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
